operand_fetch: RTL and testbench

OPERAND_FETCH -- requirements
Module: operand_fetch

---
 rtl/operand_fetch.sv | 125 ++++++++++++
 tb/tb_operand_fetch.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch.sv
// Operand fetch stage: reads two register-file operands, forwarding in-flight write-backs.
// Result appears two edges after accept and tracks write-backs while held for the consumer.
module operand_fetch #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_rs1,
  input  logic [4:0]      in_rs2,
  input  logic [4:0]      in_rd,
  input  logic [XLEN-1:0] in_tag,
  output logic            rf_en,
  output logic [4:0]      rf_rs1,
  output logic [4:0]      rf_rs2,
  input  logic [XLEN-1:0] rf_data1,
  input  logic [XLEN-1:0] rf_data2,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_op1,
  output logic [XLEN-1:0] out_op2,
  output logic [XLEN-1:0] out_tag,
  output logic [4:0]      out_rd
);

  typedef enum logic [1:0] {IDLE, READ, HOLD} state_t;

  state_t          state, state_nxt;
  logic            accept;
  logic [4:0]      rs1_q, rs2_q;
  logic            fwd1_vld, fwd2_vld;
  logic [XLEN-1:0] fwd1_dat, fwd2_dat;
  logic            hit1, hit2, hit_in1, hit_in2;
  logic [XLEN-1:0] sel1, sel2;

  assign rf_rs1 = in_rs1;
  assign rf_rs2 = in_rs2;
  assign rf_en  = accept | wb_valid;

  assign hit1    = wb_valid && (wb_rd == rs1_q)  && (rs1_q  != 5'd0);
  assign hit2    = wb_valid && (wb_rd == rs2_q)  && (rs2_q  != 5'd0);
  assign hit_in1 = wb_valid && (wb_rd == in_rs1) && (in_rs1 != 5'd0);
  assign hit_in2 = wb_valid && (wb_rd == in_rs2) && (in_rs2 != 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    accept    = 1'b0;
    unique case (state)
      IDLE:    in_ready = 1'b1;
      READ:    state_nxt = HOLD;
      HOLD:    in_ready = out_ready;
      default: state_nxt = IDLE;
    endcase
    if (flush) in_ready = 1'b0;
    accept = in_valid & in_ready;
    if (state == IDLE && accept) state_nxt = READ;
    if (state == HOLD && out_ready) state_nxt = accept ? READ : IDLE;
    if (flush) state_nxt = IDLE;
  end

  // Same-cycle write-back beats a recorded forward, which beats the (stale) RF data.
  always_comb begin
    sel1 = rf_data1;
    sel2 = rf_data2;
    if (rs1_q == 5'd0)  sel1 = '0;
    else if (hit1)      sel1 = wb_data;
    else if (fwd1_vld)  sel1 = fwd1_dat;
    if (rs2_q == 5'd0)  sel2 = '0;
    else if (hit2)      sel2 = wb_data;
    else if (fwd2_vld)  sel2 = fwd2_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_op1   <= '0;
      out_op2   <= '0;
      out_tag   <= '0;
      out_rd    <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      fwd1_vld  <= 1'b0;
      fwd2_vld  <= 1'b0;
      fwd1_dat  <= '0;
      fwd2_dat  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      fwd1_vld  <= 1'b0;
      fwd2_vld  <= 1'b0;
    end else begin
      if (state == READ) begin
        out_op1   <= sel1;
        out_op2   <= sel2;
        out_valid <= 1'b1;
      end
      if (state == HOLD) begin
        if (hit1) out_op1 <= wb_data;
        if (hit2) out_op2 <= wb_data;
        if (out_ready) out_valid <= 1'b0;
      end
      if (accept) begin
        rs1_q    <= in_rs1;
        rs2_q    <= in_rs2;
        out_rd   <= in_rd;
        out_tag  <= in_tag;
        fwd1_vld <= hit_in1;
        fwd2_vld <= hit_in2;
        fwd1_dat <= wb_data;
        fwd2_dat <= wb_data;
      end
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed scenarios then random traffic against an architectural model.
module tb_operand_fetch;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid, in_ready;
  logic [4:0]      in_rs1, in_rs2, in_rd;
  logic [XLEN-1:0] in_tag;
  logic            rf_en;
  logic [4:0]      rf_rs1, rf_rs2;
  logic [XLEN-1:0] rf_data1, rf_data2;
  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            flush;
  logic            out_valid, out_ready;
  logic [XLEN-1:0] out_op1, out_op2, out_tag;
  logic [4:0]      out_rd;

  always #5 clk = ~clk;

  operand_fetch #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_tag(in_tag),
    .rf_en(rf_en), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
    .rf_data1(rf_data1), .rf_data2(rf_data2),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op1(out_op1), .out_op2(out_op2), .out_tag(out_tag), .out_rd(out_rd)
  );

  // Environment register file: synchronous read returns the pre-write value.
  logic [XLEN-1:0] regs [32];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
      rf_data1 <= '0;
      rf_data2 <= '0;
    end else if (rf_en) begin
      rf_data1 <= regs[rf_rs1];
      rf_data2 <= regs[rf_rs2];
      if (wb_valid && wb_rd != 5'd0) regs[wb_rd] <= wb_data;
    end
  end

  // Reference: architectural register values plus the queue of accepted, undelivered requests.
  typedef struct packed {
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] tag;
  } txn_t;

  txn_t            q[$];
  bit              m_oval;
  bit              last_acc;
  logic [XLEN-1:0] arch [32];
  int              compared = 0;
  int              mismatched = 0;
  int              nd, n_acc;
  logic [XLEN-1:0] b2b_tag;

  task automatic chk(input string name, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_oval = 1'b0;
    for (int i = 0; i < 32; i++) arch[i] = '0;
  endtask

  task automatic drive(input bit v, input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                       input logic [XLEN-1:0] tag, input bit wv, input logic [4:0] wrd,
                       input logic [XLEN-1:0] wd, input bit fl, input bit ordy);
    in_valid = v; in_rs1 = r1; in_rs2 = r2; in_rd = rd; in_tag = tag;
    wb_valid = wv; wb_rd = wrd; wb_data = wd; flush = fl; out_ready = ordy;
  endtask

  // Called just after a falling edge with inputs driven; returns at the next falling edge.
  task automatic cycle();
    bit exp_rdy, acc, fire;
    #1;
    exp_rdy = !flush && (q.size() == 0 || (m_oval && out_ready));
    chk("in_ready", XLEN'(in_ready), XLEN'(exp_rdy));
    chk("rf_en", XLEN'(rf_en), XLEN'((in_valid && exp_rdy) || wb_valid));
    chk("rf_rs", XLEN'({rf_rs1, rf_rs2}), XLEN'({in_rs1, in_rs2}));
    acc  = in_valid && exp_rdy;
    fire = m_oval && out_ready && !flush;
    last_acc = acc;
    @(posedge clk);
    if (wb_valid && wb_rd != 5'd0) arch[wb_rd] = wb_data;
    if (flush) begin
      q.delete();
      m_oval = 1'b0;
    end else begin
      if (fire) begin
        void'(q.pop_front());
        m_oval = 1'b0;
      end else if (q.size() != 0) begin
        m_oval = 1'b1;
      end
      if (acc) q.push_back('{rs1: in_rs1, rs2: in_rs2, rd: in_rd, tag: in_tag});
    end
    @(negedge clk);
    chk("out_valid", XLEN'(out_valid), XLEN'(m_oval));
    if (m_oval) begin
      chk("out_tag", out_tag, q[0].tag);
      chk("out_rd", XLEN'(out_rd), XLEN'(q[0].rd));
      chk("out_op1", out_op1, arch[q[0].rs1]);
      chk("out_op2", out_op2, arch[q[0].rs2]);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, '0, 0, 0, '0, 0, 0);
    model_reset();
    #1;
    chk("rst_out_valid", XLEN'(out_valid), '0);
    chk("rst_out_op1", out_op1, '0);
    chk("rst_out_tag", out_tag, '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", XLEN'(in_ready), 32'd1);

    // Preload x5/x6 through the write-back port.
    drive(0, 0, 0, 0, '0, 1, 5'd5, 32'h11, 0, 0); cycle();
    drive(0, 0, 0, 0, '0, 1, 5'd6, 32'h22, 0, 0); cycle();

    // Plain read: result two edges after accept.
    drive(1, 5'd5, 5'd6, 5'd3, 32'h100, 0, 0, '0, 0, 0); cycle();
    chk("plain_lat1", XLEN'(out_valid), '0);
    drive(0, 0, 0, 0, '0, 0, 0, '0, 0, 0); cycle();
    chk("plain_valid", XLEN'(out_valid), 32'd1);
    chk("plain_op1", out_op1, 32'h11);
    chk("plain_op2", out_op2, 32'h22);

    // Write-back while held.
    drive(0, 0, 0, 0, '0, 1, 5'd5, 32'h99, 0, 0); cycle();
    chk("hold_fwd_op1", out_op1, 32'h99);
    chk("hold_rd", XLEN'(out_rd), 32'd3);

    // Accept-edge hazard, then READ-cycle hazard on the other operand.
    drive(1, 5'd7, 5'd6, 5'd4, 32'h101, 1, 5'd7, 32'hAB, 0, 1); cycle();
    drive(0, 0, 0, 0, '0, 1, 5'd6, 32'h55, 0, 0); cycle();
    chk("accept_hazard_op1", out_op1, 32'hAB);
    chk("read_hazard_op2", out_op2, 32'h55);

    // x0 never forwards.
    drive(1, 5'd0, 5'd5, 5'd1, 32'h102, 1, 5'd0, 32'hFFFF_FFFF, 0, 1); cycle();
    drive(0, 0, 0, 0, '0, 1, 5'd0, 32'hFFFF_FFFF, 0, 1); cycle();
    chk("x0_op1", out_op1, '0);

    // Back-to-back with in_valid and out_ready held high.
    nd = 0; n_acc = 0; b2b_tag = 32'h200;
    for (int i = 0; i < 15; i++) begin
      if (out_valid && out_tag[11:8] == 4'h2) begin
        chk("b2b_order", out_tag, 32'h200 + XLEN'(nd));
        nd++;
      end
      drive(i < 12, 5'(i), 5'(i + 1), 5'(i), b2b_tag, 0, 0, '0, 0, 1);
      cycle();
      if (last_acc) begin
        n_acc++;
        b2b_tag++;
      end
    end
    chk("b2b_accepts", XLEN'(n_acc), 32'd6);
    chk("b2b_delivered", XLEN'(nd), XLEN'(n_acc));

    // Flush during READ.
    drive(1, 5'd5, 5'd6, 5'd2, 32'h300, 0, 0, '0, 0, 0); cycle();
    drive(0, 0, 0, 0, '0, 0, 0, '0, 1, 0); cycle();
    chk("flush_valid", XLEN'(out_valid), '0);
    drive(0, 0, 0, 0, '0, 0, 0, '0, 0, 0);
    #1;
    chk("flush_in_ready", XLEN'(in_ready), 32'd1);
    cycle();

    // Asynchronous reset while holding a result.
    drive(1, 5'd5, 5'd6, 5'd2, 32'h400, 0, 0, '0, 0, 0); cycle();
    drive(0, 0, 0, 0, '0, 0, 0, '0, 0, 0); cycle();
    cycle();
    chk("pre_rst_hold", XLEN'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", XLEN'(out_valid), '0);
    chk("async_rst_tag", out_tag, '0);
    chk("async_rst_op1", out_op1, '0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", XLEN'(in_ready), 32'd1);

    // Random traffic with narrow register range to provoke hazards.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 99) < 60,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom),
            $urandom,
            $urandom_range(0, 99) < 45, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 99) < 3,
            $urandom_range(0, 99) < 55);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
